// File: rtl/status_register_unit.sv
// Execute-stage ALU and flag producer. Computes the selected 32-bit operation,
// derives {Z, C, N, V}, and commits them to the architectural status register
// when the instruction is a real, unstalled, unflushed S-bit instruction.
module status_register_unit #(
  parameter int         WIDTH        = 32,
  parameter logic [3:0] RESET_STATUS = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       exe_cmd,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic             s_bit,
  input  logic             valid,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] alu_res,
  output logic [3:0]       status,
  output logic [3:0]       flags_next
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [3:0]       status_q, status_d;
  logic [WIDTH-1:0] op_b;
  logic             cin_add;
  logic             is_arith;
  logic             is_nop;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             z_flag, c_flag, n_flag, v_flag;
  logic             commit;

  // Decode: pick the adder's second operand and carry-in; carry-in for ADC/SBC
  // is the committed C flag, never the forwarded one.
  always_comb begin
    op_b     = val2;
    cin_add  = 1'b0;
    is_arith = 1'b0;
    is_nop   = 1'b0;
    case (exe_cmd)
      CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR: ;
      CMD_ADD: is_arith = 1'b1;
      CMD_ADC: begin
        is_arith = 1'b1;
        cin_add  = status_q[2];
      end
      CMD_SUB: begin
        is_arith = 1'b1;
        op_b     = ~val2;
        cin_add  = 1'b1;
      end
      CMD_SBC: begin
        is_arith = 1'b1;
        op_b     = ~val2;
        cin_add  = status_q[2];
      end
      default: is_nop = 1'b1;
    endcase
  end

  // Single WIDTH+1 adder shared by all arithmetic ops; bit WIDTH is the carry
  // (for subtraction this is NOT borrow).
  assign sum = {1'b0, val1} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin_add};

  // Result select and flag derivation; non-arithmetic ops keep C and V.
  always_comb begin
    res = '0;
    case (exe_cmd)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_AND: res = val1 & val2;
      CMD_ORR: res = val1 | val2;
      CMD_EOR: res = val1 ^ val2;
      default: if (is_arith) res = sum[WIDTH-1:0];
    endcase
    n_flag = res[WIDTH-1];
    z_flag = (res == '0);
    if (is_arith) begin
      c_flag = sum[WIDTH];
      v_flag = (val1[WIDTH-1] == op_b[WIDTH-1]) && (res[WIDTH-1] != val1[WIDTH-1]);
    end else begin
      c_flag = status_q[2];
      v_flag = status_q[0];
    end
  end

  assign alu_res    = res;
  assign flags_next = {z_flag, c_flag, n_flag, v_flag};

  // Commit gating: flush and stall both block; a NOP never sets flags.
  always_comb begin
    commit   = valid & s_bit & ~stall & ~flush & ~is_nop;
    status_d = commit ? flags_next : status_q;
  end

  // Architectural status register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status_q <= RESET_STATUS;
    else        status_q <= status_d;
  end

  assign status = status_q;

endmodule
